// File: rtl/qspi_rx_pkg.sv
// -----------------------------------------------------------------------------
// qspi_rx_pkg
// Shared types and constants for the QSPI read-data capture stage.
//   MAX_LATENCY_DEFAULT : default largest capture delay in clk cycles
//   nibble_t            : one 4-bit QSPI data beat {io3,io2,io1,io0}
//   rx_phase_e          : which half of a byte the next capture fills
//   clamp_latency()     : saturates a latency request to the supported maximum
// -----------------------------------------------------------------------------
package qspi_rx_pkg;

    localparam int unsigned MAX_LATENCY_DEFAULT = 5;

    typedef logic [3:0] nibble_t;

    typedef enum logic {
        PH_HI = 1'b0,
        PH_LO = 1'b1
    } rx_phase_e;

    // Saturate a 3-bit latency request at max_lat.
    function automatic logic [2:0] clamp_latency(input logic [2:0] cfg, input int unsigned max_lat);
        if (32'(cfg) > max_lat) begin
            return 3'(max_lat);
        end
        return cfg;
    endfunction

endpackage

// File: rtl/qspi_rx_fifo.sv
// -----------------------------------------------------------------------------
// qspi_rx_fifo
// Byte FIFO with registered head data. Simultaneous push and pop are allowed,
// and a push into a full FIFO succeeds when a pop happens in the same cycle.
// Pushes that find the FIFO full with no pop are silently discarded here; the
// caller decides whether that is an error.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push_i     : write wdata_i this cycle
//   wdata_i    : byte to write
//   pop_i      : remove head this cycle (ignored when empty)
//   rdata_o    : registered head byte (0 when empty)
//   empty_o    : FIFO holds no entries
//   full_o     : FIFO holds DEPTH entries
//   level_o    : current occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module qspi_rx_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic [7:0]               wdata_i,
    input  logic                     pop_i,
    output logic [7:0]               rdata_o,
    output logic                     empty_o,
    output logic                     full_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    logic [7:0]       mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] count_q, count_d;
    logic [7:0]       rdata_q, rdata_d;
    logic             empty_q, full_q;
    logic             pop_ok_c, push_ok_c;

    // Pointer/level update and look-ahead of the head byte for the next cycle.
    always_comb begin
        pop_ok_c  = pop_i && !empty_q;
        push_ok_c = push_i && (!full_q || pop_ok_c);
        wr_ptr_d  = wr_ptr_q + PTR_W'(push_ok_c);
        rd_ptr_d  = rd_ptr_q + PTR_W'(pop_ok_c);
        count_d   = count_q + LVL_W'(push_ok_c) - LVL_W'(pop_ok_c);
        rdata_d   = '0;
        if (count_d != '0) begin
            // The byte being written this cycle lands exactly at the new head.
            if (push_ok_c && (wr_ptr_q == rd_ptr_d)) begin
                rdata_d = wdata_i;
            end else begin
                rdata_d = mem_q[rd_ptr_d];
            end
        end
    end

    // Storage array; contents need no reset since level gates visibility.
    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            rdata_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            rdata_q  <= rdata_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == LVL_W'(DEPTH));
        end
    end

    assign rdata_o = rdata_q;
    assign empty_o = empty_q;
    assign full_o  = full_q;
    assign level_o = count_q;

endmodule

// File: rtl/qspi_rx_capture.sv
// -----------------------------------------------------------------------------
// qspi_rx_capture
// Read-data capture stage between QSPI pads and the controller read path.
// A strobe marking the SCK edge of an expected nibble is delayed by lat_q clk
// cycles to absorb board round-trip latency; the delayed strobe samples the
// pad nibble, pairs of nibbles (high first) form bytes, bytes go to a FIFO.
// Optional feature: define QSPI_RX_STATS_EN to add the rx_count output, a
// wrapping count of bytes accepted into the FIFO (cleared only by rst).
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   cfg_load        : latch latency_cfg (clamped to MAX_LATENCY)
//   latency_cfg     : capture delay in clk cycles
//   start           : new frame; flushes delay line and partial byte
//   sample_strobe   : controller issued the SCK edge for a nibble
//   qspi_data_in    : pad data {io3,io2,io1,io0}
//   byte_data       : FIFO head byte
//   byte_valid      : FIFO not empty
//   byte_ready      : consumer pops the head when byte_valid is high
//   fifo_level      : FIFO occupancy
//   overflow        : sticky, a byte was dropped on a full FIFO
//   rx_count        : (QSPI_RX_STATS_EN only) accepted byte counter
// -----------------------------------------------------------------------------
module qspi_rx_capture
    import qspi_rx_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned MAX_LATENCY = MAX_LATENCY_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          cfg_load,
    input  logic [2:0]                    latency_cfg,
    input  logic                          start,
    input  logic                          sample_strobe,
    input  logic [3:0]                    qspi_data_in,
    output logic [7:0]                    byte_data,
    output logic                          byte_valid,
    input  logic                          byte_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
`ifdef QSPI_RX_STATS_EN
    ,
    output logic [15:0]                   rx_count
`endif
);

    logic [2:0]             lat_q, lat_d;
    logic [MAX_LATENCY-1:0] delay_q, delay_d;
    rx_phase_e              state_q, state_d;
    nibble_t                hold_q, hold_d;
    logic                   overflow_q;
    logic                   cap_en_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   push_ok_c;
    logic [7:0]             push_byte_c;
    logic                   fifo_empty;
    logic                   fifo_full;

    // Tap select: zero latency bypasses the delay line entirely.
    always_comb begin
        cap_en_c = 1'b0;
        if (lat_q == '0) begin
            cap_en_c = sample_strobe;
        end
        for (int unsigned i = 0; i < MAX_LATENCY; i++) begin
            if (32'(lat_q) == i + 1) begin
                cap_en_c = delay_q[i];
            end
        end
    end

    // Next-state: latency config, delay line shift, nibble phase FSM.
    always_comb begin
        lat_d       = lat_q;
        delay_d     = delay_q;
        state_d     = state_q;
        hold_d      = hold_q;
        push_c      = 1'b0;
        push_byte_c = {hold_q, qspi_data_in};

        if (cfg_load) begin
            lat_d = clamp_latency(latency_cfg, MAX_LATENCY);
        end

        delay_d[0] = sample_strobe;
        for (int unsigned i = 1; i < MAX_LATENCY; i++) begin
            delay_d[i] = delay_q[i-1];
        end

        // start wins over a capture in the same cycle and drops in-flight strobes.
        if (start) begin
            delay_d = '0;
            state_d = PH_HI;
        end else if (cap_en_c) begin
            case (state_q)
                PH_HI: begin
                    hold_d  = qspi_data_in;
                    state_d = PH_LO;
                end
                PH_LO: begin
                    push_c  = 1'b1;
                    state_d = PH_HI;
                end
                default: state_d = PH_HI;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lat_q   <= '0;
            delay_q <= '0;
            state_q <= PH_HI;
            hold_q  <= '0;
        end else begin
            lat_q   <= lat_d;
            delay_q <= delay_d;
            state_q <= state_d;
            hold_q  <= hold_d;
        end
    end

    // Mirrors the FIFO's acceptance rule to detect dropped bytes.
    assign pop_c     = byte_ready && byte_valid;
    assign push_ok_c = push_c && (!fifo_full || pop_c);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else if (push_c && !push_ok_c) begin
            overflow_q <= 1'b1;
        end
    end

    qspi_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_c),
        .wdata_i (push_byte_c),
        .pop_i   (pop_c),
        .rdata_o (byte_data),
        .empty_o (fifo_empty),
        .full_o  (fifo_full),
        .level_o (fifo_level)
    );

    assign byte_valid = !fifo_empty;
    assign overflow   = overflow_q;

`ifdef QSPI_RX_STATS_EN
    logic [15:0] rx_count_q;

    // Accepted-byte counter; wraps naturally at 16 bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_count_q <= '0;
        end else if (push_ok_c) begin
            rx_count_q <= rx_count_q + 16'd1;
        end
    end

    assign rx_count = rx_count_q;
`endif

endmodule

// File: tb/tb_qspi_rx_capture.sv
// -----------------------------------------------------------------------------
// tb_qspi_rx_capture
// Directed bench for qspi_rx_capture with a queue-based reference model and
// a per-cycle compare process, plus literal expectations at key points.
// -----------------------------------------------------------------------------
module tb_qspi_rx_capture;

    localparam int DEPTH = 4;
    localparam int MAXL  = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_load;
    logic [2:0] latency_cfg;
    logic       start;
    logic       sample_strobe;
    logic [3:0] qspi_data_in;
    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;
    logic [2:0] fifo_level;
    logic       overflow;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    int         m_lat;
    bit         m_lo;
    logic [3:0] m_hold;
    int         m_due[$];
    logic [7:0] m_q[$];
    bit         m_ovf;
    int         m_cyc;
    bit         chk_en;

    qspi_rx_capture #(
        .FIFO_DEPTH  (DEPTH),
        .MAX_LATENCY (MAXL)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_load      (cfg_load),
        .latency_cfg   (latency_cfg),
        .start         (start),
        .sample_strobe (sample_strobe),
        .qspi_data_in  (qspi_data_in),
        .byte_data     (byte_data),
        .byte_valid    (byte_valid),
        .byte_ready    (byte_ready),
        .fifo_level    (fifo_level),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
    endtask

    task automatic model_reset();
        m_lat  = 0;
        m_lo   = 0;
        m_hold = '0;
        m_due.delete();
        m_q.delete();
        m_ovf  = 0;
    endtask

    // One clock of behaviour: strobe at cycle s is captured at cycle s+lat
    // unless a start occurs anywhere in [s, s+lat].
    task automatic model_step();
        bit         cap;
        bit         pop;
        bit         push;
        logic [7:0] b;
        cap  = 0;
        push = 0;
        b    = '0;
        pop  = byte_ready && (m_q.size() != 0);
        if (start) begin
            m_due.delete();
            m_lo = 0;
        end else begin
            if (sample_strobe && m_lat == 0) cap = 1;
            while (m_due.size() != 0 && m_due[0] <= m_cyc) begin
                if (m_due[0] == m_cyc) cap = 1;
                void'(m_due.pop_front());
            end
            if (sample_strobe && m_lat != 0) m_due.push_back(m_cyc + m_lat);
            if (cap) begin
                if (!m_lo) begin
                    m_hold = qspi_data_in;
                    m_lo   = 1;
                end else begin
                    b    = {m_hold, qspi_data_in};
                    push = 1;
                    m_lo = 0;
                end
            end
        end
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(b);
            else m_ovf = 1;
        end
        if (cfg_load) m_lat = (int'(latency_cfg) > MAXL) ? MAXL : int'(latency_cfg);
        m_cyc++;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
    endtask

    task automatic tick(input logic s, input logic [3:0] d, input logic r);
        sample_strobe = s;
        qspi_data_in  = d;
        byte_ready    = r;
        step();
        start    = 1'b0;
        cfg_load = 1'b0;
    endtask

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            check("byte_valid", int'(byte_valid), int'(m_q.size() != 0));
            check("fifo_level", int'(fifo_level), m_q.size());
            check("overflow", int'(overflow), int'(m_ovf));
            if (m_q.size() != 0) check("byte_data", int'(byte_data), int'(m_q[0]));
        end
    end

    initial begin
        rst           = 1'b1;
        cfg_load      = 1'b0;
        latency_cfg   = '0;
        start         = 1'b0;
        sample_strobe = 1'b0;
        qspi_data_in  = '0;
        byte_ready    = 1'b0;
        chk_en        = 0;
        m_cyc         = 0;
        model_reset();
        #1;
        check("rst_byte_valid", int'(byte_valid), 0);
        check("rst_fifo_level", int'(fifo_level), 0);
        check("rst_byte_data", int'(byte_data), 0);
        check("rst_overflow", int'(overflow), 0);
        repeat (3) step();
        rst    = 1'b0;
        chk_en = 1;
        repeat (2) tick(1'b0, 4'h0, 1'b0);

        // Zero latency: A then 5 -> A5 visible the cycle after the second strobe
        tick(1'b1, 4'hA, 1'b0);
        check("lat0_not_yet", int'(byte_valid), 0);
        tick(1'b1, 4'h5, 1'b0);
        check("lat0_valid", int'(byte_valid), 1);
        check("lat0_data", int'(byte_data), 'hA5);
        tick(1'b0, 4'h0, 1'b1);
        tick(1'b0, 4'h0, 1'b0);
        check("lat0_popped", int'(byte_valid), 0);

        // Latency 3: pads carry junk 7 except on the two capture cycles
        latency_cfg = 3'd3;
        cfg_load    = 1'b1;
        tick(1'b0, 4'h7, 1'b0);
        tick(1'b1, 4'h7, 1'b0);
        tick(1'b1, 4'h7, 1'b0);
        tick(1'b0, 4'h7, 1'b0);
        tick(1'b0, 4'h3, 1'b0);
        check("lat3_not_yet", int'(byte_valid), 0);
        tick(1'b0, 4'hC, 1'b0);
        check("lat3_valid", int'(byte_valid), 1);
        check("lat3_data", int'(byte_data), 'h3C);
        tick(1'b0, 4'h7, 1'b1);
        tick(1'b0, 4'h7, 1'b0);

        // Latency request 7 clamps to 5
        latency_cfg = 3'd7;
        cfg_load    = 1'b1;
        tick(1'b0, 4'h7, 1'b0);
        tick(1'b1, 4'h7, 1'b0);
        tick(1'b1, 4'h7, 1'b0);
        repeat (3) tick(1'b0, 4'h7, 1'b0);
        tick(1'b0, 4'h6, 1'b0);
        check("lat5_not_yet", int'(byte_valid), 0);
        tick(1'b0, 4'h9, 1'b0);
        check("lat5_valid", int'(byte_valid), 1);
        check("lat5_data", int'(byte_data), 'h69);
        tick(1'b0, 4'h7, 1'b1);
        tick(1'b0, 4'h7, 1'b0);

        // Overflow: five bytes into a four-deep FIFO with no consumer
        latency_cfg = 3'd0;
        cfg_load    = 1'b1;
        tick(1'b0, 4'h0, 1'b0);
        for (int i = 1; i <= 5; i++) begin
            tick(1'b1, 4'h0, 1'b0);
            tick(1'b1, 4'(i), 1'b0);
        end
        tick(1'b0, 4'h0, 1'b0);
        check("ovf_level", int'(fifo_level), 4);
        check("ovf_flag", int'(overflow), 1);
        for (int i = 1; i <= 4; i++) begin
            check("ovf_pop_data", int'(byte_data), i);
            tick(1'b0, 4'h0, 1'b1);
        end
        check("ovf_drained", int'(byte_valid), 0);

        // start discards a half-built byte
        tick(1'b1, 4'hF, 1'b0);
        start = 1'b1;
        tick(1'b0, 4'h0, 1'b0);
        tick(1'b1, 4'h1, 1'b0);
        tick(1'b1, 4'h2, 1'b0);
        check("start_level", int'(fifo_level), 1);
        check("start_data", int'(byte_data), 'h12);
        check("start_ovf_kept", int'(overflow), 1);
        tick(1'b0, 4'h0, 1'b1);
        tick(1'b0, 4'h0, 1'b0);

        // Clear overflow, fill, then push and pop together on a full FIFO
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_overflow", int'(overflow), 0);
        for (int i = 1; i <= 4; i++) begin
            tick(1'b1, 4'(i), 1'b0);
            tick(1'b1, 4'(i), 1'b0);
        end
        check("full_level", int'(fifo_level), 4);
        tick(1'b1, 4'h5, 1'b0);
        tick(1'b1, 4'h5, 1'b1);
        check("pushpop_level", int'(fifo_level), 4);
        check("pushpop_ovf", int'(overflow), 0);
        check("pushpop_head", int'(byte_data), 'h22);
        tick(1'b0, 4'h0, 1'b0);

        // Asynchronous reset mid-frame with a high nibble held
        tick(1'b1, 4'hE, 1'b0);
        #3;
        rst = 1'b1;
        #1;
        check("async_byte_valid", int'(byte_valid), 0);
        check("async_fifo_level", int'(fifo_level), 0);
        check("async_byte_data", int'(byte_data), 0);
        check("async_overflow", int'(overflow), 0);
        step();
        rst = 1'b0;
        tick(1'b1, 4'h4, 1'b0);
        tick(1'b1, 4'h8, 1'b0);
        check("post_rst_level", int'(fifo_level), 1);
        check("post_rst_data", int'(byte_data), 'h48);
        tick(1'b0, 4'h0, 1'b1);
        repeat (2) tick(1'b0, 4'h0, 1'b0);

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/qspi_rx_capture.md
Name: qspi_rx_capture

Overview:
- Read-data capture stage between the QSPI pad inputs and the QSPI controller's read path.
- Compensates round-trip latency of 0..MAX_LATENCY clk cycles, matching the board/PMOD delay that the bench models with its nibble shift buffer.
- Assembles returned nibbles into bytes and buffers them in a small FIFO for the controller.
- Synthesizable; one instance per QSPI bus.

Parameters:
- FIFO_DEPTH, 4, byte FIFO entries (power of two, >=2).
- MAX_LATENCY, 5, largest supported capture delay in clk cycles; latency_cfg values above this are clamped.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- cfg_load  in  1  latch latency_cfg this cycle.
- latency_cfg  in  3  capture delay in clk cycles.
- start  in  1  begin new read frame; flushes all capture state.
- sample_strobe  in  1  controller issued the SCK edge whose data nibble is expected.
- qspi_data_in  in  4  pad data {io3,io2,io1,io0}.
- byte_data  out  8  FIFO head byte.
- byte_valid  out  1  FIFO not empty.
- byte_ready  in  1  consumer pops the head when byte_valid is high.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy.
- overflow  out  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset (asynchronous, rst=1), all outputs 0:
  - lat_q=0, delay line cleared, nibble phase=HI, FIFO empty.
  - byte_data=0, byte_valid=0, fifo_level=0, overflow=0.
- Config:
  - On clk with cfg_load=1: lat_q <= min(latency_cfg, MAX_LATENCY).
  - A changed value takes effect on the next cycle.
  - Loading while strobes are in flight is permitted; in-flight strobes use the new tap position (undefined alignment, software must not do this).
- Delay line:
  - MAX_LATENCY-bit shift register; bit0 <= sample_strobe every cycle.
  - cap_en = sample_strobe when lat_q=0, else delay[lat_q-1].
  - With lat_q=N, the nibble is sampled from qspi_data_in exactly N cycles after the strobe cycle.
- Nibble FSM, states HI and LO:
  - HI with cap_en: hold_q <= qspi_data_in; go to LO.
  - LO with cap_en: form byte {hold_q, qspi_data_in} and push it; go to HI.
  - Without cap_en: stay in the current state.
- start=1:
  - Delay line cleared, state forced to HI, any partial byte discarded.
  - start has priority over cap_en in the same cycle.
  - FIFO contents and overflow are kept.
- FIFO:
  - Push and pop in the same cycle are both allowed; the level is unchanged.
  - A push when full and not popping drops the byte and sets overflow=1.
  - A push when full with a pop in the same cycle succeeds.
  - overflow clears only on rst.
  - byte_data is registered head data, valid together with byte_valid.
  - A pushed byte becomes visible at byte_valid 1 cycle after the LO capture.
  - Total latency: strobe to byte_valid = lat_q+1 cycles after the second strobe.
- Pointers wrap modulo FIFO_DEPTH; fifo_level counts 0..FIFO_DEPTH.
- Reset asserted mid-frame: abandons everything; no partial byte survives.

Optional Feature:
- Macro QSPI_RX_STATS_EN.
- Defined: adds output port rx_count [15:0].
  - Increments on every successful FIFO push; wraps at 0xFFFF to 0.
  - Cleared by rst only, not by start.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package qspi_rx_pkg holds:
  - constant MAX_LATENCY_DEFAULT=5.
  - typedef nibble_t (logic [3:0]).
  - enum rx_phase_e {PH_HI, PH_LO}.
- One sub-module: qspi_rx_fifo (parameterised byte FIFO: push/pop/level/full/empty).
- The delay line and nibble FSM stay in the top module.

Test Plan:
- lat=0, strobes on cycles 10,11 with data 0xA then 0x5 -> byte 0xA5 with byte_valid high on cycle 12.
- lat=3 via cfg_load, strobes on cycles 20,21, data 0x3 valid only on cycle 23 and 0xC only on cycle 24 -> byte 0x3C, byte_valid on cycle 25; wrong-cycle data never captured.
- latency_cfg=7 -> clamps to 5; byte captured 5 cycles after each strobe.
- byte_ready=0, push 5 bytes 0x01..0x05 with FIFO_DEPTH=4 -> fifo_level=4, overflow=1, pops return 0x01..0x04.
- One strobe (nibble 0xF), then start, then strobes with 0x1,0x2 -> only 0x12 appears.
- Full FIFO with simultaneous push and pop -> level stays 4, no overflow; rst mid-frame -> all outputs 0 immediately (async).
